// File: rtl/edge_det_pkg.sv
// Shared types and default parameter values for the multi-channel edge detector.
package edge_det_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    localparam int DEF_NUM_CH          = 4;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/edge_det_channel.sv
// One channel: input synchronizer, debounce counter, edge qualification and sticky flag.
module edge_det_channel
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    input  logic [1:0] mode,
    input  logic       flag_clr,
    output logic       level,
    output logic       pulse,
    output logic       flag
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   sync_q;
    logic                   differ;
    logic                   commit;
    logic                   qual;
    edge_mode_e             emode;

    assign sync_q = sync[SYNC_STAGES-1];
    assign differ = (sync_q != level);
    // Commit on the edge that closes the DEBOUNCE_CYCLES-th differing cycle.
    assign commit = differ && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign emode  = edge_mode_e'(mode);

    always_comb begin
        qual = 1'b0;
        if (commit) begin
            if (sync_q)
                qual = (emode == EDGE_RISE) || (emode == EDGE_BOTH);
            else
                qual = (emode == EDGE_FALL) || (emode == EDGE_BOTH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
            flag  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], data_in};
            if (commit) begin
                level <= sync_q;
                cnt   <= '0;
            end else if (differ) begin
                cnt <= cnt + CW'(1);
            end else begin
                cnt <= '0;
            end
            pulse <= qual;
            // A new event outranks a simultaneous clear.
            flag  <= qual | (flag & ~flag_clr);
        end
    end

endmodule

// File: rtl/multi_edge_detector.sv
// Array of independent debounced edge-detecting channels with sticky event flags.
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int NUM_CH          = DEF_NUM_CH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   data_in,
    input  logic [2*NUM_CH-1:0] mode,
    input  logic [NUM_CH-1:0]   flag_clr,
    output logic [NUM_CH-1:0]   level_out,
    output logic [NUM_CH-1:0]   pulse_out,
    output logic [NUM_CH-1:0]   flag_out
);

    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
        $error("multi_edge_detector: NUM_CH must be 1..32");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("multi_edge_detector: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("multi_edge_detector: DEBOUNCE_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        edge_det_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .data_in  (data_in[i]),
            .mode     (mode[2*i +: 2]),
            .flag_clr (flag_clr[i]),
            .level    (level_out[i]),
            .pulse    (pulse_out[i]),
            .flag     (flag_out[i])
        );
    end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Scoreboarded bench: expected pulses are queued when stimulus is driven and matched cycle by cycle.
module tb_multi_edge_detector;

    logic       clk;
    logic       rst;
    logic [3:0] data_in;
    logic [7:0] mode;
    logic [3:0] flag_clr;
    logic [3:0] level_out;
    logic [3:0] pulse_out;
    logic [3:0] flag_out;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    localparam int LAT = 6;

    multi_edge_detector #(
        .NUM_CH          (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .mode      (mode),
        .flag_clr  (flag_clr),
        .level_out (level_out),
        .pulse_out (pulse_out),
        .flag_out  (flag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: every cycle pulse_out must equal the queued mask, or be zero.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (pulse_out !== e.mask) begin
                errors++;
                $display("FAIL pulse cyc=%0d got %b expected %b", cyc, pulse_out, e.mask);
            end
        end else if (pulse_out !== 4'b0000) begin
            checks++;
            errors++;
            $display("FAIL stray_pulse cyc=%0d got %b expected 0000", cyc, pulse_out);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input int dly, input logic [3:0] m);
        exp_t e;
        e.cyc  = cyc + dly;
        e.mask = m;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        checks++;
        if (level_out !== 4'b0000) begin errors++; $display("FAIL reset_level got %b expected 0000", level_out); end
        checks++;
        if (pulse_out !== 4'b0000) begin errors++; $display("FAIL reset_pulse got %b expected 0000", pulse_out); end
        checks++;
        if (flag_out !== 4'b0000) begin errors++; $display("FAIL reset_flag got %b expected 0000", flag_out); end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_rise_ch0();
        data_in[0] = 1'b1;
        expect_pulse(LAT, 4'b0001);
        step(LAT - 1);
        checks++;
        if (level_out[0] !== 1'b0) begin errors++; $display("FAIL rise0_early level got %b expected 0", level_out[0]); end
        step(1);
        checks++;
        if (level_out[0] !== 1'b1) begin errors++; $display("FAIL rise0_level got %b expected 1", level_out[0]); end
        checks++;
        if (flag_out[0] !== 1'b1) begin errors++; $display("FAIL rise0_flag got %b expected 1", flag_out[0]); end
        step(3);
        checks++;
        if (flag_out[0] !== 1'b1) begin errors++; $display("FAIL rise0_flag_hold got %b expected 1", flag_out[0]); end
    endtask

    task automatic test_glitch_ch1();
        data_in[1] = 1'b1;
        step(3);
        data_in[1] = 1'b0;
        step(10);
        checks++;
        if (level_out[1] !== 1'b0) begin errors++; $display("FAIL glitch3_level got %b expected 0", level_out[1]); end
        checks++;
        if (flag_out[1] !== 1'b0) begin errors++; $display("FAIL glitch3_flag got %b expected 0", flag_out[1]); end
        data_in[1] = 1'b1;
        expect_pulse(LAT, 4'b0010);
        expect_pulse(LAT + 4, 4'b0010);
        step(4);
        data_in[1] = 1'b0;
        step(2);
        checks++;
        if (level_out[1] !== 1'b1) begin errors++; $display("FAIL glitch4_level_hi got %b expected 1", level_out[1]); end
        step(6);
        checks++;
        if (level_out[1] !== 1'b0) begin errors++; $display("FAIL glitch4_level_lo got %b expected 0", level_out[1]); end
        checks++;
        if (flag_out[1] !== 1'b1) begin errors++; $display("FAIL glitch4_flag got %b expected 1", flag_out[1]); end
        flag_clr[1] = 1'b1;
        step(1);
        flag_clr[1] = 1'b0;
        checks++;
        if (flag_out[1] !== 1'b0) begin errors++; $display("FAIL clr1_flag got %b expected 0", flag_out[1]); end
    endtask

    task automatic test_fall_only_ch2();
        data_in[2] = 1'b1;
        step(8);
        checks++;
        if (level_out[2] !== 1'b1 || flag_out[2] !== 1'b0) begin
            errors++; $display("FAIL fall2_rise got level=%b flag=%b expected level=1 flag=0", level_out[2], flag_out[2]);
        end
        data_in[2] = 1'b0;
        expect_pulse(LAT, 4'b0100);
        step(LAT);
        checks++;
        if (level_out[2] !== 1'b0 || flag_out[2] !== 1'b1) begin
            errors++; $display("FAIL fall2_fall got level=%b flag=%b expected level=0 flag=1", level_out[2], flag_out[2]);
        end
        flag_clr[2] = 1'b1;
        step(1);
        flag_clr[2] = 1'b0;
        mode[5:4]   = 2'b00;
        data_in[2]  = 1'b1;
        step(8);
        checks++;
        if (level_out[2] !== 1'b1 || flag_out[2] !== 1'b0) begin
            errors++; $display("FAIL none2_rise got level=%b flag=%b expected level=1 flag=0", level_out[2], flag_out[2]);
        end
        data_in[2] = 1'b0;
        step(8);
        checks++;
        if (level_out[2] !== 1'b0 || flag_out[2] !== 1'b0) begin
            errors++; $display("FAIL none2_fall got level=%b flag=%b expected level=0 flag=0", level_out[2], flag_out[2]);
        end
    endtask

    task automatic test_set_wins_ch0();
        data_in[0]  = 1'b0;
        flag_clr[0] = 1'b1;
        step(1);
        flag_clr[0] = 1'b0;
        checks++;
        if (flag_out[0] !== 1'b0) begin errors++; $display("FAIL pre_clr0 got %b expected 0", flag_out[0]); end
        step(8);
        data_in[0] = 1'b1;
        expect_pulse(LAT, 4'b0001);
        step(LAT - 1);
        flag_clr[0] = 1'b1;
        step(1);
        checks++;
        if (flag_out[0] !== 1'b1) begin errors++; $display("FAIL set_wins got %b expected 1", flag_out[0]); end
        step(1);
        flag_clr[0] = 1'b0;
        checks++;
        if (flag_out[0] !== 1'b0) begin errors++; $display("FAIL clr_after got %b expected 0", flag_out[0]); end
    endtask

    task automatic test_reset_mid_ch3();
        data_in[3] = 1'b1;
        step(4);
        rst     = 1'b1;
        data_in = 4'b1000;
        step(2);
        checks++;
        if (level_out !== 4'b0000 || flag_out !== 4'b0000) begin
            errors++; $display("FAIL mid_reset got level=%b flag=%b expected 0000/0000", level_out, flag_out);
        end
        step(6);
        rst = 1'b0;
        expect_pulse(LAT, 4'b1000);
        step(LAT - 1);
        checks++;
        if (level_out[3] !== 1'b0) begin errors++; $display("FAIL rel3_early got %b expected 0", level_out[3]); end
        step(1);
        checks++;
        if (level_out[3] !== 1'b1 || flag_out[3] !== 1'b1) begin
            errors++; $display("FAIL rel3 got level=%b flag=%b expected 1/1", level_out[3], flag_out[3]);
        end
    endtask

    task automatic test_back_to_back();
        mode     = 8'hFF;
        flag_clr = 4'b1111;
        step(1);
        flag_clr = 4'b0000;
        data_in  = 4'b0111;
        expect_pulse(LAT, 4'b1111);
        step(LAT);
        checks++;
        if (level_out !== 4'b0111) begin errors++; $display("FAIL all_level got %b expected 0111", level_out); end
        checks++;
        if (flag_out !== 4'b1111) begin errors++; $display("FAIL all_flag got %b expected 1111", flag_out); end
        step(4);
    endtask

    initial begin
        rst      = 1'b1;
        data_in  = 4'b0000;
        mode     = 8'b11_10_11_01;
        flag_clr = 4'b0000;
        test_reset();
        test_rise_ch0();
        test_glitch_ch1();
        test_fall_only_ch2();
        test_set_wins_ch0();
        test_reset_mid_ch3();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flip-flop depth per channel (>=2).
REQ-003 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required before the filtered level changes (>=1).
REQ-004 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port data_in  input  NUM_CH  asynchronous raw input levels, one bit per channel.
REQ-007 Port mode  input  2*NUM_CH  per-channel edge select, bits [2i+1:2i] for channel i: 00 none, 01 rising, 10 falling, 11 both.
REQ-008 Port flag_clr  input  NUM_CH  per-channel sticky-flag clear, level-sensitive, sampled each cycle.
REQ-009 Port level_out  output  NUM_CH  synchronized, debounced level per channel.
REQ-010 Port pulse_out  output  NUM_CH  one-cycle pulse per qualified edge.
REQ-011 Port flag_out  output  NUM_CH  sticky event flag per channel.

Function
REQ-012 Each channel SHALL pass data_in[i] through a SYNC_STAGES-deep flip-flop chain; only the last stage feeds the debounce logic.
REQ-013 Each channel SHALL hold a debounce counter of width clog2(DEBOUNCE_CYCLES+1); it increments while synchronized value != level_out[i] and clears to 0 whenever they are equal.
REQ-014 When the synchronized value has differed from level_out[i] for DEBOUNCE_CYCLES consecutive cycles, level_out[i] SHALL take the new value on the next edge and the counter SHALL clear on that same edge.
REQ-015 A steady data_in change SHALL appear on level_out exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples it (default 6).
REQ-016 Any excursion at the synchronizer output shorter than DEBOUNCE_CYCLES cycles SHALL produce no level_out, pulse_out or flag_out change.
REQ-017 pulse_out[i] SHALL be high for exactly one cycle, registered on the same edge level_out[i] changes, when the change matches mode: 0->1 with mode 01/11, 1->0 with mode 10/11.
REQ-018 mode SHALL be evaluated at the edge on which level_out changes; mode 00 suppresses pulse_out and flag_out but level_out SHALL still track.
REQ-019 flag_out[i] SHALL set on the edge pulse_out[i] asserts and remain set until a cycle with flag_clr[i]=1 clears it.
REQ-020 Simultaneous qualified event and flag_clr[i] SHALL leave flag_out[i]=1 (set wins).
REQ-021 Channels SHALL be fully independent; simultaneous events on all channels SHALL all be reported in the same cycle.

Reset
REQ-022 While rst=1, synchronizer stages, counters, level_out, pulse_out and flag_out SHALL all be 0 on the next edge.
REQ-023 rst asserted mid-debounce SHALL discard the pending transition; no pulse follows for it.
REQ-024 data_in held high through reset release SHALL be treated as a 0->1 transition, producing level_out=1 and a rising pulse (if enabled) SYNC_STAGES+DEBOUNCE_CYCLES edges after the first post-reset edge.

Structure
REQ-025 Shared package edge_det_pkg SHALL hold the 2-bit mode enum (EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH) and default parameter constants.
REQ-026 Per-channel logic SHALL live in sub-module edge_det_channel (synchronizer, debounce counter, edge qualify, sticky flag), replicated NUM_CH times by generate.
REQ-027 Illegal parameter values (SYNC_STAGES<2, DEBOUNCE_CYCLES<1, NUM_CH<1) SHALL cause an elaboration-time error.

Verification
REQ-028 Defaults, mode[1:0]=01, data_in[0] 0->1 held -> level_out[0]=1 and pulse_out[0] high exactly one cycle 6 edges after the sampling edge; flag_out[0]=1 thereafter.
REQ-029 data_in[1] high-glitch for 3 cycles, mode both -> level_out[1], pulse_out[1], flag_out[1] stay 0; 4-cycle glitch -> rise pulse then fall pulse.
REQ-030 mode[5:4]=10, data_in[2] rise then fall -> only the falling transition pulses; mode 00 -> level_out[2] tracks, no pulse, no flag.
REQ-031 flag_clr[0]=1 in the same cycle as a new qualified pulse on channel 0 -> flag_out[0] remains 1; clr alone next cycle -> 0.
REQ-032 rst asserted 2 cycles into debounce of a rising data_in[3] -> all outputs 0, no pulse; data_in[3] held high -> rising pulse 6 edges after reset release.
REQ-033 All four channels toggled on the same edge, mode both -> all pulse_out bits high in the same single cycle.
